alu_sequencer_param: RTL

//  Parametrised board-level ALU front end: a successor to the fixed 6-bit switch/button ALU top.

---
 rtl/alu_sequencer_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer_param.sv
// Board-level ALU front end: synchronised edge-detected load buttons latch A, B and opcode from the
// switches; result and {zero,carry,overflow} are registered one cycle after the opcode load.
module alu_sequencer_param #(
    parameter int DATA_WIDTH = 6,
    parameter int NB_OP      = 6,
    parameter int STRICT_SEQ = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_SWs,
    input  logic [2:0]            i_buttons,
    output logic [DATA_WIDTH-1:0] o_led,
    output logic [2:0]            o_flags,
    output logic                  o_valid,
    output logic [1:0]            o_state
);

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [DATA_WIDTH-1:0] DW_L = DATA_WIDTH[DATA_WIDTH-1:0];

    typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, WAIT_OP = 2'b10, DONE = 2'b11} state_t;

    logic [2:0]            r_sync1, r_sync2, r_sync3;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_led;
    logic [NB_OP-1:0]      r_op;
    logic [2:0]            r_flags;
    logic                  r_valid, r_calc;
    state_t                r_state, w_state_next;

    logic [2:0]            w_pulse;
    logic                  w_pa, w_pb, w_po;
    logic                  w_ld_a, w_ld_b, w_ld_op;
    logic [DATA_WIDTH:0]   w_sum, w_diff;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_carry, w_ovf, w_known;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= i_buttons;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Priority A > B > OP is applied before the sequencer decides acceptance.
    assign w_pulse = r_sync2 & ~r_sync3;
    assign w_pa    = w_pulse[2];
    assign w_pb    = w_pulse[1] & ~w_pulse[2];
    assign w_po    = w_pulse[0] & ~w_pulse[1] & ~w_pulse[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= WAIT_A;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_op      = 1'b0;
        if (STRICT_SEQ == 0) begin
            w_ld_a  = w_pa;
            w_ld_b  = w_pb;
            w_ld_op = w_po;
        end else begin
            case (r_state)
                WAIT_A:  if (w_pa) begin w_ld_a  = 1'b1; w_state_next = WAIT_B;  end
                WAIT_B:  if (w_pb) begin w_ld_b  = 1'b1; w_state_next = WAIT_OP; end
                WAIT_OP: if (w_po) begin w_ld_op = 1'b1; w_state_next = DONE;    end
                DONE:    if (w_pa) begin w_ld_a  = 1'b1; w_state_next = WAIT_B;  end
                default: w_state_next = WAIT_A;
            endcase
        end
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_known = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_res   = w_sum[DATA_WIDTH-1:0];
                w_carry = w_sum[DATA_WIDTH];
                w_ovf   = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1]) &&
                          (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[DATA_WIDTH-1:0];
                w_carry = w_diff[DATA_WIDTH];
                w_ovf   = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1]) &&
                          (w_diff[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOR: w_res = ~(r_a | r_b);
            OP_SRL: w_res = (r_b >= DW_L) ? '0 : (r_a >> r_b);
            OP_SRA: w_res = (r_b >= DW_L) ? {DATA_WIDTH{r_a[DATA_WIDTH-1]}}
                                          : $unsigned($signed(r_a) >>> r_b);
            default: w_known = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_calc  <= 1'b0;
            r_led   <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_calc <= w_ld_op;
            if (w_ld_a)  r_a  <= i_SWs;
            if (w_ld_b)  r_b  <= i_SWs;
            if (w_ld_op) r_op <= i_SWs[NB_OP-1:0];
            if (r_calc) begin
                r_led   <= w_res;
                r_flags <= {w_known && (w_res == '0), w_carry, w_ovf};
            end
            // A fresh operand always invalidates the result, even one landing this edge.
            if (w_ld_a || w_ld_b) r_valid <= 1'b0;
            else if (r_calc)      r_valid <= 1'b1;
        end
    end

    assign o_led   = r_led;
    assign o_flags = r_flags;
    assign o_valid = r_valid;
    assign o_state = r_state;

endmodule
